// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register scoreboard (busy bit) and a
// sequential clear engine.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   write_enable/_reg/_data    writeback port; it also clears busy[write_reg]
//   read_reg1/2 -> read_data1/2  combinational reads, bypassed from writeback
//   busy1/2                    registered busy bits of read_reg1/2, no bypass
//   reserve_en, reserve_reg    set busy[reserve_reg] (producer issued)
//   clear_req, clear_busy      start the sequential clear / clear in progress
//
// Optional feature: define REGFILE_ZERO_REG_EN to hard-wire register 0 to zero.
// In that mode register 0 always reads 0 and is never busy.
module regfile_sb #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic              busy1,
   output logic              busy2,
   input  logic              reserve_en,
   input  logic [ADDR_W-1:0] reserve_reg,
   input  logic              clear_req,
   output logic              clear_busy
);

   localparam int DEPTH = 2 ** ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                         state, state_nxt;
   logic [ADDR_W-1:0]              idx, idx_nxt;
   logic [DEPTH-1:0][DATA_W-1:0]   regs;
   logic [DEPTH-1:0]               busy;

   // Writes and reserves only land in IDLE; with the zero register enabled,
   // anything aimed at address 0 is dropped here so it never reaches state.
   logic wr_ok, rsv_ok;
   assign wr_ok  = write_enable && (state == IDLE) && !(ZERO_REG && (write_reg == '0));
   assign rsv_ok = reserve_en   && (state == IDLE) && !(ZERO_REG && (reserve_reg == '0));

   assign clear_busy = (state == CLEAR);

   // ---------------- FSM ----------------
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            if (clear_req) begin
               state_nxt = CLEAR;
               idx_nxt   = '0;
            end
         end
         CLEAR: begin
            // exit on the last index so idx never wraps
            if (idx == ADDR_W'(DEPTH - 1)) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   // ---------------- state ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         regs  <= '0;
         busy  <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (state == CLEAR) begin
            regs[idx] <= '0;
            busy[idx] <= 1'b0;
         end else begin
            if (wr_ok) begin
               regs[write_reg] <= write_data;
               busy[write_reg] <= 1'b0;
            end
            // after the write so a same-address reserve leaves busy set
            if (rsv_ok)
               busy[reserve_reg] <= 1'b1;
         end
      end
   end

   // ---------------- read ports ----------------
   // wr_ok already excludes CLEAR and (optionally) address 0, so the bypass
   // needs no further qualification.
   always_comb begin
      read_data1 = regs[read_reg1];
      if (wr_ok && (write_reg == read_reg1))
         read_data1 = write_data;
      if (ZERO_REG && (read_reg1 == '0))
         read_data1 = '0;
   end

   always_comb begin
      read_data2 = regs[read_reg2];
      if (wr_ok && (write_reg == read_reg2))
         read_data2 = write_data;
      if (ZERO_REG && (read_reg2 == '0))
         read_data2 = '0;
   end

   assign busy1 = busy[read_reg1];
   assign busy2 = busy[read_reg2];

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

`ifdef REGFILE_ZERO_REG_EN
   localparam bit ZERO = 1'b1;
`else
   localparam bit ZERO = 1'b0;
`endif

   logic          clk, rst_n;
   logic          write_enable, reserve_en, clear_req;
   logic [AW-1:0] write_reg, reserve_reg, read_reg1, read_reg2;
   logic [DW-1:0] write_data, read_data1, read_data2;
   logic          busy1, busy2, clear_busy;

   int checks = 0;
   int passes = 0;

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
      .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(read_data1), .read_data2(read_data2),
      .busy1(busy1), .busy2(busy2),
      .reserve_en(reserve_en), .reserve_reg(reserve_reg),
      .clear_req(clear_req), .clear_busy(clear_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   // A clear is tracked as "cycles remaining"; the register being zeroed is
   // DEPTH - remaining.
   logic [DW-1:0] m_regs [DEPTH];
   bit            m_busy [DEPTH];
   int            m_left;

   function automatic void m_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_left = 0;
   endfunction

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (ZERO && a == 0) return '0;
      if (m_left == 0 && write_enable && write_reg == a) return write_data;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      return m_busy[a];
   endfunction

   function automatic void m_edge();
      if (!rst_n) begin
         m_reset();
      end else if (m_left > 0) begin
         m_regs[DEPTH - m_left] = '0;
         m_busy[DEPTH - m_left] = 1'b0;
         m_left--;
      end else begin
         if (write_enable && !(ZERO && write_reg == 0)) begin
            m_regs[write_reg] = write_data;
            m_busy[write_reg] = 1'b0;
         end
         if (reserve_en && !(ZERO && reserve_reg == 0))
            m_busy[reserve_reg] = 1'b1;
         if (clear_req) m_left = DEPTH;
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra, input logic cr,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      write_enable = we; write_reg = wa; write_data = wd;
      reserve_en = re; reserve_reg = ra; clear_req = cr;
      read_reg1 = r1; read_reg2 = r2;
   endtask

   task automatic tick();
      @(posedge clk);
      m_edge();
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      m_reset();
      tick(); tick();
      rst_n = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
         drive(0, 0, 0, 0, 0, 0, AW'(a), AW'(DEPTH - 1 - a));
         #1;
         checks++;
         if (read_data1 !== 8'h00) $display("FAIL reset_rd1 a=%0d got %h want 00", a, read_data1);
         else passes++;
         checks++;
         if (read_data2 !== 8'h00) $display("FAIL reset_rd2 a=%0d got %h want 00", DEPTH - 1 - a, read_data2);
         else passes++;
         checks++;
         if (busy1 !== 1'b0 || busy2 !== 1'b0) $display("FAIL reset_busy a=%0d got %b%b want 00", a, busy1, busy2);
         else passes++;
      end
      checks++;
      if (clear_busy !== 1'b0) $display("FAIL reset_clear_busy got %b want 0", clear_busy);
      else passes++;
   endtask

   task automatic test_bypass();
      drive(1, 5, 8'hA7, 0, 0, 0, 5, 4);
      #1;
      checks++;
      if (read_data1 !== 8'hA7) $display("FAIL bypass_same_cycle got %h want a7", read_data1);
      else passes++;
      tick();
      drive(0, 0, 0, 0, 0, 0, 5, 5);
      #1;
      checks++;
      if (read_data1 !== 8'hA7 || read_data2 !== 8'hA7)
         $display("FAIL bypass_after_edge got %h/%h want a7/a7", read_data1, read_data2);
      else passes++;
   endtask

   task automatic test_reserve_wins();
      drive(0, 0, 0, 1, 3, 0, 3, 3);
      tick();
      drive(1, 3, 8'h11, 1, 3, 0, 3, 3);
      #1;
      checks++;
      if (busy1 !== 1'b1 || read_data1 !== 8'h11)
         $display("FAIL reserve_write_cycle got busy=%b rd=%h want busy=1 rd=11", busy1, read_data1);
      else passes++;
      tick();
      drive(0, 0, 0, 0, 0, 0, 3, 3);
      #1;
      checks++;
      if (busy1 !== 1'b1 || read_data1 !== 8'h11)
         $display("FAIL reserve_wins got busy=%b rd=%h want busy=1 rd=11", busy1, read_data1);
      else passes++;
      // a plain write then clears busy one cycle later
      drive(1, 3, 8'h22, 0, 0, 0, 3, 3);
      #1;
      checks++;
      if (busy1 !== 1'b1) $display("FAIL busy_no_bypass got %b want 1", busy1);
      else passes++;
      tick();
      drive(0, 0, 0, 0, 0, 0, 3, 3);
      #1;
      checks++;
      if (busy1 !== 1'b0) $display("FAIL busy_cleared_by_write got %b want 0", busy1);
      else passes++;
   endtask

   task automatic test_clear();
      int n;
      for (int a = 0; a < DEPTH; a++) begin
         drive(1, AW'(a), 8'hFF, 1, AW'(a), 0, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      tick();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         drive(i == 0, 2, 8'h55, i == 1, 6, i == 2, 2, AW'(i % DEPTH));
         #1;
         if (!clear_busy) break;
         n++;
         if (i == 0) begin
            checks++;
            if (read_data1 !== 8'hFF) $display("FAIL clear_no_bypass got %h want ff", read_data1);
            else passes++;
         end
         tick();
      end
      checks++;
      if (n !== DEPTH) $display("FAIL clear_length got %0d cycles want %0d", n, DEPTH);
      else passes++;
      for (int a = 0; a < DEPTH; a++) begin
         drive(0, 0, 0, 0, 0, 0, AW'(a), AW'(a));
         #1;
         checks++;
         if (read_data1 !== 8'h00 || busy1 !== 1'b0)
            $display("FAIL clear_result a=%0d got rd=%h busy=%b want 00/0", a, read_data1, busy1);
         else passes++;
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      #1;
      checks++;
      if (clear_busy !== 1'b0) $display("FAIL clear_req_ignored got %b want 0", clear_busy);
      else passes++;
   endtask

   task automatic test_reset_during_clear();
      for (int a = 0; a < DEPTH; a++) begin
         drive(1, AW'(a), DW'($urandom_range(1, 255)), 0, 0, 0, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick(); tick();
      #1 rst_n = 1'b0;
      m_reset();
      #1;
      checks++;
      if (clear_busy !== 1'b0) $display("FAIL reset_abort_clear got %b want 0", clear_busy);
      else passes++;
      @(negedge clk);
      for (int a = 0; a < DEPTH; a++) begin
         drive(0, 0, 0, 0, 0, 0, AW'(a), AW'(a));
         #1;
         checks++;
         if (read_data1 !== 8'h00) $display("FAIL reset_abort_rd a=%0d got %h want 00", a, read_data1);
         else passes++;
      end
      rst_n = 1'b1;
      tick();
      #1;
      checks++;
      if (clear_busy !== 1'b0) $display("FAIL reset_abort_idle got %b want 0", clear_busy);
      else passes++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
               1'($urandom_range(0, 2) == 0), AW'($urandom),
               1'($urandom_range(0, 24) == 0), AW'($urandom), AW'($urandom));
         #1;
         checks++;
         if (read_data1 !== exp_rd(read_reg1) || read_data2 !== exp_rd(read_reg2))
            $display("FAIL rand_rd i=%0d got %h/%h want %h/%h", i, read_data1, read_data2,
                     exp_rd(read_reg1), exp_rd(read_reg2));
         else passes++;
         checks++;
         if (busy1 !== exp_busy(read_reg1) || busy2 !== exp_busy(read_reg2))
            $display("FAIL rand_busy i=%0d got %b%b want %b%b", i, busy1, busy2,
                     exp_busy(read_reg1), exp_busy(read_reg2));
         else passes++;
         checks++;
         if (clear_busy !== (m_left != 0))
            $display("FAIL rand_clear_busy i=%0d got %b want %b", i, clear_busy, m_left != 0);
         else passes++;
         tick();
      end
   endtask

`ifdef REGFILE_ZERO_REG_EN
   task automatic test_zero_reg();
      while (m_left != 0) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         tick();
      end
      drive(1, 0, 8'h3C, 1, 0, 0, 0, 0);
      #1;
      checks++;
      if (read_data1 !== 8'h00 || busy1 !== 1'b0)
         $display("FAIL zero_reg_write_cycle got rd=%h busy=%b want 00/0", read_data1, busy1);
      else passes++;
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (read_data1 !== 8'h00 || busy1 !== 1'b0)
         $display("FAIL zero_reg_after got rd=%h busy=%b want 00/0", read_data1, busy1);
      else passes++;
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      m_reset();
      @(negedge clk);
      test_reset();
      test_bypass();
      test_reserve_wins();
      test_clear();
      test_reset_during_clear();
      test_random();
`ifdef REGFILE_ZERO_REG_EN
      test_zero_reg();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 8, register width in bits.
REQ-002 Parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 The module SHALL use one clock and an asynchronous, active-low reset, on the ports clk and rst_n.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port write_enable  input  1  writeback strobe.
REQ-007 Port write_reg  input  ADDR_W  writeback address.
REQ-008 Port write_data  input  DATA_W  writeback data.
REQ-009 Ports read_reg1 and read_reg2  input  ADDR_W  read addresses.
REQ-010 Ports read_data1 and read_data2  output  DATA_W  read data.
REQ-011 Ports busy1 and busy2  output  1  scoreboard busy flag of read_reg1 and read_reg2.
REQ-012 Port reserve_en  input  1  marks reserve_reg pending (producer issued).
REQ-013 Port reserve_reg  input  ADDR_W  address to reserve.
REQ-014 Port clear_req  input  1  starts a sequential clear of all registers.
REQ-015 Port clear_busy  output  1  high while a clear is in progress.

Function
REQ-016 Reads SHALL be combinational: read_dataN = registers[read_regN].
REQ-017 Bypass: when write_enable=1, clear_busy=0 and write_reg==read_regN, read_dataN SHALL equal write_data in the same cycle.
REQ-018 On a rising clk edge with write_enable=1 and clear_busy=0, registers[write_reg] SHALL take write_data; the write SHALL also clear busy[write_reg].
REQ-019 On a rising clk edge with reserve_en=1 and clear_busy=0, busy[reserve_reg] SHALL be set.
REQ-020 When a reserve and a write target the same address in one cycle, the data SHALL be written and busy SHALL end at 1 (reserve wins).
REQ-021 busyN SHALL be the registered busy[read_regN] with no bypass, so a write clears it one cycle later.
REQ-022 The FSM SHALL have two states: IDLE and CLEAR.
REQ-023 IDLE->CLEAR on a clk edge with clear_req=1; the clear index SHALL be loaded with 0.
REQ-024 In CLEAR, each cycle SHALL zero registers[idx] and busy[idx], then increment idx; after idx=DEPTH-1 the FSM SHALL return to IDLE.
REQ-025 A clear SHALL take exactly DEPTH cycles; clear_busy SHALL be 1 in CLEAR and 0 in IDLE.
REQ-026 In CLEAR, write_enable, reserve_en and clear_req SHALL be ignored, and reads SHALL return stored contents without bypass.
REQ-027 A clear_req that arrives together with write or reserve in IDLE SHALL give precedence to the write/reserve on that edge; CLEAR starts next cycle.
REQ-028 The clear index SHALL be ADDR_W bits wide, and wrap-around SHALL NOT occur because the exit condition is idx==DEPTH-1.

Reset
REQ-029 While rst_n=0, all registers SHALL be 0, all busy bits 0, the FSM in IDLE, idx 0 and clear_busy 0.
REQ-030 Reset asserted during CLEAR SHALL abort the clear immediately; after deassertion the FSM SHALL be in IDLE.

Configuration
REQ-031 Macro REGFILE_ZERO_REG_EN, when defined: register 0 SHALL always read 0, writes and reserves to address 0 SHALL be discarded, busy for address 0 SHALL always be 0, and bypass SHALL NOT apply to address 0.
REQ-032 Without REGFILE_ZERO_REG_EN, register 0 SHALL behave like every other register.

Verification
REQ-033 Reset, then read all addresses with defaults (8/3) -> every read_data=0x00 and every busy=0.
REQ-034 write_enable=1, write_reg=5, write_data=0xA7, read_reg1=5 in the same cycle -> read_data1=0xA7 combinationally, and it remains 0xA7 after the edge.
REQ-035 Reserve reg 3, then on the next cycle write reg 3 with 0x11 while reserving reg 3 again -> busy1 (read_reg1=3) stays 1 and read_data1=0x11.
REQ-036 Load regs 0..7 with 0xFF, pulse clear_req -> clear_busy high for exactly 8 cycles, write of 0x55 to reg 2 during the clear is ignored, and all regs read 0x00 afterwards.
REQ-037 Pulse rst_n low at the 4th cycle of a clear -> clear_busy=0 immediately and all regs read 0x00.
REQ-038 With REGFILE_ZERO_REG_EN defined, write 0x3C to reg 0 and reserve reg 0 -> read_data1=0x00 and busy1=0, including in the write cycle.
